// File: rtl/controle_acesso_interface.sv
// Sequential requester for the interface-1 permission checker: holds each request
// stable on the checker, samples its permit bit, and locks out after repeated denials.
module controle_acesso_interface #(
    parameter int HOLD_CYCLES = 2,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [2:0] perfil,
    input  logic [2:0] funcao,
    output logic       req_ready,
    output logic [2:0] chk_perfil,
    output logic [2:0] chk_funcao,
    input  logic       chk_result,
    output logic       grant,
    output logic       deny,
    output logic       locked,
    output logic [1:0] fail_count
);

    localparam int CNT_MAX = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_CYCLES - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PRESENT = 2'd1;
    localparam logic [1:0] RESP    = 2'd2;
    localparam logic [1:0] LOCK    = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       perfil_q, perfil_d;
    logic [2:0]       funcao_q, funcao_d;
    logic             permit_q, permit_d;
    logic [1:0]       fail_q, fail_d;

    // One counter serves both the hold window and the lockout; they never overlap.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        perfil_d = perfil_q;
        funcao_d = funcao_q;
        permit_d = permit_q;
        fail_d   = fail_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    perfil_d = perfil;
                    funcao_d = funcao;
                    cnt_d    = HOLD_LOAD;
                    state_d  = PRESENT;
                end
            end
            PRESENT: begin
                if (cnt_q == '0) begin
                    permit_d = chk_result;
                    state_d  = RESP;
                    if (chk_result) begin
                        fail_d = 2'd0;
                    end else if (fail_q != 2'd3) begin
                        fail_d = fail_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                // The count was already updated at the sampling edge.
                if (int'(fail_q) >= MAX_FAIL) begin
                    cnt_d   = LOCK_LOAD;
                    state_d = LOCK;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    fail_d  = 2'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            perfil_q <= 3'd0;
            funcao_q <= 3'd0;
            permit_q <= 1'b0;
            fail_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            perfil_q <= perfil_d;
            funcao_q <= funcao_d;
            permit_q <= permit_d;
            fail_q   <= fail_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign locked     = (state_q == LOCK);
    assign grant      = (state_q == RESP) &&  permit_q;
    assign deny       = (state_q == RESP) && !permit_q;
    assign chk_perfil = perfil_q;
    assign chk_funcao = funcao_q;
    assign fail_count = fail_q;

endmodule

// File: tb/tb_controle_acesso_interface.sv
// Directed bench for controle_acesso_interface with default parameters
// (HOLD_CYCLES=2, MAX_FAIL=3, LOCK_CYCLES=16); the bench drives chk_result directly.
module tb_controle_acesso_interface;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [2:0] perfil;
    logic [2:0] funcao;
    logic       req_ready;
    logic [2:0] chk_perfil;
    logic [2:0] chk_funcao;
    logic       chk_result;
    logic       grant;
    logic       deny;
    logic       locked;
    logic [1:0] fail_count;

    int checks = 0;
    int errors = 0;

    controle_acesso_interface #(
        .HOLD_CYCLES(2),
        .MAX_FAIL   (3),
        .LOCK_CYCLES(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .perfil    (perfil),
        .funcao    (funcao),
        .req_ready (req_ready),
        .chk_perfil(chk_perfil),
        .chk_funcao(chk_funcao),
        .chk_result(chk_result),
        .grant     (grant),
        .deny      (deny),
        .locked    (locked),
        .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept a request at E0 and return 1 time unit after E2 (the RESP cycle).
    task automatic req_to_resp(input logic [2:0] p, input logic [2:0] f, input logic r);
        perfil     = p;
        funcao     = f;
        chk_result = r;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] pv [4];
        logic [2:0] fv [4];
        int  n;
        logic pulse;

        pv[0] = 3'b001; pv[1] = 3'b110; pv[2] = 3'b011; pv[3] = 3'b101;
        fv[0] = 3'b100; fv[1] = 3'b010; fv[2] = 3'b111; fv[3] = 3'b001;

        rst_n = 1'b0; req_valid = 1'b0; perfil = 3'd0; funcao = 3'd0; chk_result = 1'b0;
        #12;
        chk("rst_ready", req_ready, 1);
        chk("rst_grant", grant, 0);
        chk("rst_deny", deny, 0);
        chk("rst_locked", locked, 0);
        chk("rst_fail", fail_count, 0);
        chk("rst_chk_perfil", chk_perfil, 0);
        chk("rst_chk_funcao", chk_funcao, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Grant path
        perfil = 3'b001; funcao = 3'b000; chk_result = 1'b1; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("gp_chk_perfil_E0", chk_perfil, 3'b001);
        chk("gp_chk_funcao_E0", chk_funcao, 3'b000);
        chk("gp_ready_E0", req_ready, 0);
        chk("gp_grant_E0", grant, 0);
        tick();
        chk("gp_grant_E1", grant, 0);
        tick();
        chk("gp_grant_E2", grant, 1);
        chk("gp_deny_E2", deny, 0);
        chk("gp_fail_E2", fail_count, 0);
        chk("gp_ready_E2", req_ready, 0);
        tick();
        chk("gp_grant_E3", grant, 0);
        chk("gp_ready_E3", req_ready, 1);

        // Deny then grant
        req_to_resp(3'b001, 3'b110, 1'b0);
        chk("dg_deny", deny, 1);
        chk("dg_grant0", grant, 0);
        chk("dg_fail1", fail_count, 1);
        tick();
        chk("dg_deny_end", deny, 0);
        chk("dg_ready", req_ready, 1);
        req_to_resp(3'b100, 3'b000, 1'b1);
        chk("dg_grant", grant, 1);
        chk("dg_fail0", fail_count, 0);
        tick();

        // Lockout after three consecutive denials
        req_to_resp(3'b010, 3'b110, 1'b0);
        chk("lk_fail1", fail_count, 1);
        tick();
        req_to_resp(3'b010, 3'b111, 1'b0);
        chk("lk_fail2", fail_count, 2);
        chk("lk_locked_early", locked, 0);
        tick();
        req_to_resp(3'b011, 3'b110, 1'b0);
        chk("lk_fail3", fail_count, 3);
        chk("lk_deny3", deny, 1);
        chk("lk_locked_resp", locked, 0);
        tick();
        chk("lk_locked_entry", locked, 1);
        chk("lk_ready_entry", req_ready, 0);
        n = 0; pulse = 1'b0;
        perfil = 3'b111; funcao = 3'b111; chk_result = 1'b1; req_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (locked !== 1'b1) break;
            n++;
            if (grant || deny) pulse = 1'b1;
            tick();
            req_valid = 1'b0;
        end
        chk("lk_cycles", n, 16);
        chk("lk_no_pulse", pulse, 0);
        chk("lk_locked_after", locked, 0);
        chk("lk_ready_after", req_ready, 1);
        chk("lk_fail_after", fail_count, 0);
        chk("lk_dropped_req", chk_perfil, 3'b011);

        // Only the value at the sampling edge matters
        perfil = 3'b010; funcao = 3'b011; chk_result = 1'b0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0; chk_result = 1'b1;
        tick();
        chk_result = 1'b0;
        tick();
        chk_result = 1'b1;
        chk("se_deny", deny, 1);
        chk("se_fail1", fail_count, 1);
        tick();
        perfil = 3'b010; funcao = 3'b011; chk_result = 1'b1; req_valid = 1'b1;
        tick();
        req_valid = 1'b0; chk_result = 1'b0;
        tick();
        chk_result = 1'b1;
        tick();
        chk_result = 1'b0;
        chk("se_grant", grant, 1);
        chk("se_fail0", fail_count, 0);
        tick();

        // Back-to-back with req_valid held high
        perfil = pv[0]; funcao = fv[0]; chk_result = 1'b1; req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bb_chk_perfil", chk_perfil, pv[k]);
            chk("bb_chk_funcao", chk_funcao, fv[k]);
            chk("bb_ready_busy", req_ready, 0);
            perfil = ~pv[k]; funcao = ~fv[k];
            tick();
            tick();
            chk("bb_grant", grant, 1);
            tick();
            chk("bb_ready", req_ready, 1);
            if (k < 3) begin
                perfil = pv[k+1]; funcao = fv[k+1];
            end else begin
                req_valid = 1'b0;
            end
        end
        tick();

        // Reset during PRESENT
        req_to_resp(3'b110, 3'b001, 1'b0);
        chk("rp_fail_pre", fail_count, 1);
        tick();
        perfil = 3'b101; funcao = 3'b101; chk_result = 1'b1; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rp_ready", req_ready, 1);
        chk("rp_chk_perfil", chk_perfil, 0);
        chk("rp_fail", fail_count, 0);
        chk("rp_grant", grant, 0);
        @(negedge clk) rst_n = 1'b1;
        pulse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (grant || deny) pulse = 1'b1;
        end
        chk("rp_no_pulse", pulse, 0);
        chk("rp_ready_after", req_ready, 1);

        // Reset during LOCK
        for (int i = 0; i < 3; i++) begin
            req_to_resp(3'b000, 3'b111, 1'b0);
            tick();
        end
        tick();
        tick();
        chk("rl_locked_pre", locked, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rl_locked", locked, 0);
        chk("rl_fail", fail_count, 0);
        chk("rl_ready", req_ready, 1);
        chk("rl_deny", deny, 0);
        @(negedge clk) rst_n = 1'b1;
        pulse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (grant || deny || locked) pulse = 1'b1;
        end
        chk("rl_quiet_after", pulse, 0);
        chk("rl_ready_after", req_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
